// File: rtl/aes_encryptor.sv
// Iterative AES-128 encryption core: one full round per clock, round keys expanded on the fly.
// Byte S-box shared by the SubBytes and SubWord paths.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // The S-box is evaluated as the inverse a^254 in GF(2^8) followed by the affine map.
    // Zero maps to zero because every product in the chain contains a.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = x;
        for (int unsigned i = 0; i < 8; i++) begin
            if (z[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    always_comb begin
        sq  = a;
        inv = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_encryptor (
    input  logic         clk,
    input  logic         reset,
    input  logic         io_ready,
    input  logic [127:0] msg_pt,
    input  logic [127:0] key,
    output logic [127:0] msg_en,
    output logic         aes_ready,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t         fsm;
    logic [127:0] state;
    logic [127:0] rkey;
    logic [7:0]   rcon;
    logic [3:0]   round;

    logic [7:0]   sb_out [16];
    logic [31:0]  rot_w3;
    logic [31:0]  sub_w;
    logic [31:0]  temp;
    logic [127:0] next_key;
    logic [127:0] shifted;
    logic [127:0] mixed;
    logic [127:0] round_out;
    logic [127:0] final_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
        aes_sbox u_sbox (
            .a (state[127-8*i -: 8]),
            .y (sb_out[i])
        );
    end

    assign rot_w3 = {rkey[23:0], rkey[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_sub_word
        aes_sbox u_sbox (
            .a (rot_w3[31-8*j -: 8]),
            .y (sub_w[31-8*j -: 8])
        );
    end

    always_comb begin
        temp = sub_w ^ {rcon, 24'h0};
        next_key[127:96] = rkey[127:96] ^ temp;
        next_key[95:64]  = rkey[95:64]  ^ next_key[127:96];
        next_key[63:32]  = rkey[63:32]  ^ next_key[95:64];
        next_key[31:0]   = rkey[31:0]   ^ next_key[63:32];
    end

    // Byte index is 4*c + r (column-major); row r of the output takes column c + r.
    always_comb begin
        shifted = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                shifted[127-8*(4*c+r) -: 8] = sb_out[4'(4*((c+r)%4)+r)];
            end
        end
    end

    always_comb begin
        mixed = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
        end
        round_out = mixed ^ next_key;
        final_out = shifted ^ next_key;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm       <= IDLE;
            state     <= '0;
            rkey      <= '0;
            rcon      <= 8'h01;
            round     <= '0;
            msg_en    <= '0;
            aes_ready <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (io_ready) begin
                        state <= msg_pt ^ key;
                        rkey  <= key;
                        rcon  <= 8'h01;
                        round <= 4'd1;
                        fsm   <= RUN;
                    end
                end
                RUN: begin
                    rkey  <= next_key;
                    rcon  <= xtime(rcon);
                    round <= round + 4'd1;
                    if (round == 4'd10) begin
                        msg_en    <= final_out;
                        aes_ready <= 1'b1;
                        fsm       <= DONE;
                    end else begin
                        state <= round_out;
                    end
                end
                DONE: begin
                    if (!io_ready) begin
                        aes_ready <= 1'b0;
                        fsm       <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign busy = (fsm == RUN);
endmodule

// File: tb/tb_aes_encryptor.sv
// Self-checking bench for aes_encryptor: FIPS-197 vectors, handshake, reset abort and
// random vectors against a byte-array AES-128 model.

module tb_aes_encryptor;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         io_ready = 1'b0;
    logic [127:0] msg_pt = '0;
    logic [127:0] key = '0;
    logic [127:0] msg_en;
    logic         aes_ready;
    logic         busy;

    int checks = 0;
    int failures = 0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RT_PT  = 128'hece298dcece298dcece298dcece298dc;
    localparam logic [127:0] RT_CT  = 128'hdaec3055df058e1c39e814ea76f6747e;

    logic [7:0] sbox_t [256];

    aes_encryptor dut (
        .clk       (clk),
        .reset     (reset),
        .io_ready  (io_ready),
        .msg_pt    (msg_pt),
        .key       (key),
        .msg_en    (msg_en),
        .aes_ready (aes_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Carry-less product reduced by long division with the AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--)
            if (p[k]) p = p ^ (15'h11b << (k - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_t[x] = s;
        end
    endtask

    task automatic aes_model(input logic [127:0] p, input logic [127:0] k,
                             output logic [127:0] ct, output logic [127:0] k10);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] tmp;
        logic [31:0] wk;
        logic [7:0]  rc;
        logic [7:0]  acc;
        int          mx [4][4];
        mx = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            t = s;
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c+r] = t[4*((c+r)%4)+r];
            if (rnd < 10) begin
                t = s;
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++) acc = acc ^ gmul(8'(mx[r][j]), t[4*c+j]);
                        s[4*c+r] = acc;
                    end
            end
            for (int i = 0; i < 16; i++) begin
                wk = w[4*rnd + i/4];
                s[i] = s[i] ^ wk[31-8*(i%4) -: 8];
            end
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        k10 = {w[40], w[41], w[42], w[43]};
    endtask

    // Raises io_ready with the given block; lat = edges from the start edge to aes_ready, -1 on timeout.
    task automatic start_wait(input logic [127:0] p, input logic [127:0] k, output int lat);
        @(negedge clk);
        msg_pt   = p;
        key      = k;
        io_ready = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (aes_ready) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release_start();
        @(negedge clk);
        io_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        io_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (msg_en !== 128'h0) begin failures++; $display("FAIL reset_msg_en got=%h exp=0", msg_en); end
        checks++; if (aes_ready !== 1'b0) begin failures++; $display("FAIL reset_aes_ready got=%b exp=0", aes_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (dut.round !== 4'd0 || dut.rcon !== 8'h01) begin
            failures++; $display("FAIL reset_round_rcon got=%h/%h exp=0/01", dut.round, dut.rcon);
        end
        checks++; if (dut.state !== 128'h0 || dut.rkey !== 128'h0) begin
            failures++; $display("FAIL reset_state_rkey got=%h/%h exp=0/0", dut.state, dut.rkey);
        end
        @(negedge clk);
        reset = 1'b0;
        io_ready = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_fips_c1();
        int lat;
        start_wait(C1_PT, C1_KEY, lat);
        checks++; if (lat !== 10) begin failures++; $display("FAIL c1_latency got=%0d exp=10", lat); end
        checks++; if (msg_en !== C1_CT) begin failures++; $display("FAIL c1_ct got=%h exp=%h", msg_en, C1_CT); end
        release_start();
    endtask

    task automatic test_fips_b();
        int lat;
        start_wait(B_PT, B_KEY, lat);
        checks++; if (lat !== 10) begin failures++; $display("FAIL b_latency got=%0d exp=10", lat); end
        checks++; if (msg_en !== B_CT) begin failures++; $display("FAIL b_ct got=%h exp=%h", msg_en, B_CT); end
        checks++; if (dut.rkey !== B_K10) begin failures++; $display("FAIL b_rkey10 got=%h exp=%h", dut.rkey, B_K10); end
        release_start();
    endtask

    task automatic test_round_trip();
        int lat;
        start_wait(RT_PT, C1_KEY, lat);
        checks++; if (lat !== 10) begin failures++; $display("FAIL rt_latency got=%0d exp=10", lat); end
        checks++; if (msg_en !== RT_CT) begin failures++; $display("FAIL rt_ct got=%h exp=%h", msg_en, RT_CT); end
        release_start();
    endtask

    task automatic test_hold_high();
        int busy_cnt;
        busy_cnt = 0;
        @(negedge clk);
        msg_pt   = C1_PT;
        key      = C1_KEY;
        io_ready = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
        end
        checks++; if (busy_cnt !== 10) begin failures++; $display("FAIL hold_busy_cycles got=%0d exp=10", busy_cnt); end
        checks++; if (aes_ready !== 1'b1) begin failures++; $display("FAIL hold_ready_held got=%b exp=1", aes_ready); end
        checks++; if (msg_en !== C1_CT) begin failures++; $display("FAIL hold_ct got=%h exp=%h", msg_en, C1_CT); end
        @(negedge clk);
        io_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (aes_ready !== 1'b0) begin failures++; $display("FAIL hold_ready_clear got=%b exp=0", aes_ready); end
        checks++; if (msg_en !== C1_CT) begin failures++; $display("FAIL hold_ct_kept got=%h exp=%h", msg_en, C1_CT); end
        @(posedge clk);
    endtask

    task automatic test_input_change();
        logic [127:0] p, k, exp_ct, exp_k10;
        int lat;
        p = {$urandom(), $urandom(), $urandom(), $urandom()};
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        aes_model(p, k, exp_ct, exp_k10);
        @(negedge clk);
        msg_pt   = p;
        key      = k;
        io_ready = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        msg_pt   = ~p;
        key      = {$urandom(), $urandom(), $urandom(), $urandom()};
        io_ready = 1'b0;
        @(negedge clk);
        io_ready = 1'b1;
        lat = -1;
        for (int n = 5; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (aes_ready) begin
                lat = n;
                break;
            end
        end
        checks++; if (lat !== 10) begin failures++; $display("FAIL midrun_latency got=%0d exp=10", lat); end
        checks++; if (msg_en !== exp_ct) begin failures++; $display("FAIL midrun_ct got=%h exp=%h", msg_en, exp_ct); end
        release_start();
    endtask

    task automatic test_reset_mid();
        int spurious;
        int lat;
        @(negedge clk);
        msg_pt   = C1_PT;
        key      = C1_KEY;
        io_ready = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (dut.round !== 4'd5) begin failures++; $display("FAIL abort_round got=%0d exp=5", dut.round); end
        @(negedge clk);
        reset    = 1'b1;
        io_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (msg_en !== 128'h0) begin failures++; $display("FAIL abort_msg_en got=%h exp=0", msg_en); end
        checks++; if (aes_ready !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL abort_flags got=%b%b exp=00", aes_ready, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        spurious = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (aes_ready || busy || msg_en !== 128'h0) spurious++;
        end
        checks++; if (spurious !== 0) begin failures++; $display("FAIL abort_no_result got=%0d exp=0", spurious); end
        start_wait(C1_PT, C1_KEY, lat);
        checks++; if (lat !== 10) begin failures++; $display("FAIL after_abort_latency got=%0d exp=10", lat); end
        checks++; if (msg_en !== C1_CT) begin failures++; $display("FAIL after_abort_ct got=%h exp=%h", msg_en, C1_CT); end
        release_start();
    endtask

    task automatic test_back_to_back();
        int lat;
        int hold_bad;
        start_wait(C1_PT, C1_KEY, lat);
        checks++; if (msg_en !== C1_CT) begin failures++; $display("FAIL b2b_first_ct got=%h exp=%h", msg_en, C1_CT); end
        @(negedge clk);
        io_ready = 1'b0;
        @(negedge clk);
        msg_pt   = B_PT;
        key      = B_KEY;
        io_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_restart_busy got=%b exp=1", busy); end
        hold_bad = 0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (aes_ready) begin
                lat = n;
                break;
            end
            if (msg_en !== C1_CT) hold_bad++;
        end
        checks++; if (hold_bad !== 0) begin failures++; $display("FAIL b2b_hold got=%0d bad cycles exp=0", hold_bad); end
        checks++; if (lat !== 10) begin failures++; $display("FAIL b2b_latency got=%0d exp=10", lat); end
        checks++; if (msg_en !== B_CT) begin failures++; $display("FAIL b2b_second_ct got=%h exp=%h", msg_en, B_CT); end
        release_start();
    endtask

    task automatic test_random();
        logic [127:0] p, k, exp_ct, exp_k10;
        int lat;
        for (int v = 0; v < 6; v++) begin
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            aes_model(p, k, exp_ct, exp_k10);
            start_wait(p, k, lat);
            checks++; if (lat !== 10) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=10", v, lat); end
            checks++; if (msg_en !== exp_ct) begin failures++; $display("FAIL rand%0d_ct got=%h exp=%h", v, msg_en, exp_ct); end
            checks++; if (dut.rkey !== exp_k10) begin failures++; $display("FAIL rand%0d_rkey got=%h exp=%h", v, dut.rkey, exp_k10); end
            release_start();
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_round_trip();
        test_hold_high();
        test_input_change();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
